// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the main-memory arbiter: state encoding,
// owner encoding, bus width and default memory latency.
package mem_arbiter_pkg;

   localparam int DATA_W          = 16;
   localparam int MEM_LATENCY_DEF = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT_I = 2'd1,
      GRANT_D = 2'd2,
      WRITE_D = 2'd3
   } arb_state_t;

   typedef enum logic {
      OWNER_I = 1'b0,
      OWNER_D = 1'b1
   } owner_t;

endpackage

// File: rtl/mem_outstanding_ctr.sv
// Saturating up/down counter with zero flag; tracks reads in flight.
// Ports: clk, rst (sync, high), inc, dec -> count, zero.
module mem_outstanding_ctr #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   input  logic         dec,
   output logic [W-1:0] count,
   output logic         zero
);

   localparam logic [W-1:0] MAX = '1;

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (inc && !dec) begin
         // Saturate rather than wrap; overflow is caught below.
         if (count != MAX) count <= count + W'(1);
      end else if (dec && !inc) begin
         if (count != '0) count <= count - W'(1);
      end
   end

   assign zero = (count == '0);

   a_no_overflow : assert property (
      @(posedge clk) disable iff (rst) !(inc && !dec && count == MAX)
   );

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single main-memory port between I-cache fills and
// D-cache fills/write-through stores, round-robin on ties.
// Ports: I side (i_req/i_mem_read/i_addr -> i_grant/i_data_valid),
// D side (d_req/d_mem_read/d_addr/d_write/d_wdata -> d_grant/
// d_data_valid/d_write_done), memory bus (mem_enable/mem_wr/
// mem_addr/mem_wdata <- mem_data_valid).
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int MEM_LATENCY = MEM_LATENCY_DEF,
   parameter int CNT_W       = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_req,
   input  logic              i_mem_read,
   input  logic [DATA_W-1:0] i_addr,
   output logic              i_grant,
   output logic              i_data_valid,
   input  logic              d_req,
   input  logic              d_mem_read,
   input  logic [DATA_W-1:0] d_addr,
   input  logic              d_write,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_grant,
   output logic              d_data_valid,
   output logic              d_write_done,
   output logic              mem_enable,
   output logic              mem_wr,
   output logic [DATA_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_data_valid
);

   arb_state_t       state, state_nxt;
   owner_t           last_owner, last_nxt;
   logic [CNT_W-1:0] outstanding;
   logic             zero;
   logic             d_want;
   logic             rd_issue;
   logic             rd_return;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         last_owner <= OWNER_I;
      end else begin
         state      <= state_nxt;
         last_owner <= last_nxt;
      end
   end

   assign d_want = d_write | d_req;

   always_comb begin
      state_nxt    = state;
      last_nxt     = last_owner;
      i_grant      = 1'b0;
      d_grant      = 1'b0;
      mem_enable   = 1'b0;
      mem_wr       = 1'b0;
      mem_addr     = '0;
      mem_wdata    = '0;
      d_write_done = 1'b0;
      unique case (state)
         IDLE: begin
            // D wins alone, or on a tie when I owned last.
            if (d_want && (!i_req || last_owner == OWNER_I)) begin
               last_nxt  = OWNER_D;
               state_nxt = d_write ? WRITE_D : GRANT_D;
            end else if (i_req) begin
               last_nxt  = OWNER_I;
               state_nxt = GRANT_I;
            end
         end
         GRANT_I: begin
            i_grant    = 1'b1;
            mem_enable = i_mem_read;
            mem_addr   = i_addr;
            if (!i_req && zero) state_nxt = IDLE;
         end
         GRANT_D: begin
            d_grant    = 1'b1;
            mem_enable = d_mem_read;
            mem_addr   = d_addr;
            if (!d_req && zero) state_nxt = IDLE;
         end
         WRITE_D: begin
            mem_enable   = 1'b1;
            mem_wr       = 1'b1;
            mem_addr     = d_addr;
            mem_wdata    = d_wdata;
            d_write_done = 1'b1;
            state_nxt    = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign rd_issue  = mem_enable & ~mem_wr;
   // Valids with nothing in flight are stale (e.g. after reset).
   assign rd_return = mem_data_valid & ~zero;

   mem_outstanding_ctr #(
      .W (CNT_W)
   ) u_ctr (
      .clk   (clk),
      .rst   (rst),
      .inc   (rd_issue),
      .dec   (rd_return),
      .count (outstanding),
      .zero  (zero)
   );

   assign i_data_valid = rd_return & i_grant;
   assign d_data_valid = rd_return & d_grant;

   a_latency_bound : assert property (
      @(posedge clk) disable iff (rst)
      int'(outstanding) <= MEM_LATENCY + 1
   );

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single multi-cycle main-memory port between the I-cache fill FSM and the D-cache side (fill FSM plus write-through stores).
- Grants one requester at a time and forwards only that requester's read/write onto the memory bus.
- Routes memory_data_valid back to the owner only, and holds ownership until every read issued in the burst has returned.
- Sits between the two cache fill FSMs and the memory model, at the top of the memory subsystem.

Parameters:
MEM_LATENCY, 4, cycles from mem_enable (read) to matching mem_data_valid; bounds the outstanding counter
CNT_W, 4, width of the outstanding-read counter; must hold MEM_LATENCY+1

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
i_req  in  1  I-cache fill FSM busy (held for the whole fill)
i_mem_read  in  1  I-side read request this cycle
i_addr  in  16  I-side read address
i_grant  out  1  I-side owns memory; I FSM advances its read offset only while high
i_data_valid  out  1  memory_data_valid routed to I-side
d_req  in  1  D-cache fill FSM busy
d_mem_read  in  1  D-side read request this cycle
d_addr  in  16  D-side read/write address
d_write  in  1  D-side write-through store request (held until d_write_done)
d_wdata  in  16  store data
d_grant  out  1  D-side owns memory for a fill
d_data_valid  out  1  memory_data_valid routed to D-side
d_write_done  out  1  one-cycle pulse: store accepted by memory
mem_enable  out  1  memory access strobe
mem_wr  out  1  1 = write, 0 = read (valid with mem_enable)
mem_addr  out  16  memory address
mem_wdata  out  16  memory write data
mem_data_valid  in  1  memory read data valid

Behaviour:
- States: IDLE, GRANT_I, GRANT_D, WRITE_D. State, last_owner bit, and outstanding counter are registered.
- Reset: state=IDLE, outstanding=0, last_owner=I. All outputs 0 at reset: grants, mem_enable, mem_wr, d_write_done, routed valids; mem_addr and mem_wdata 0.
- Reset mid-burst aborts immediately. Any returning valids after reset are dropped, because outstanding=0.

Arbitration in IDLE (evaluated each cycle; transition on the next edge):
- Both d_write and d_req may request D-side; d_write beats d_req.
- Between the I and D sides, round-robin: the side not equal to last_owner wins a tie.
- Single requester wins outright.
- Winner D with d_write → WRITE_D. Winner D with d_req → GRANT_D. Winner I → GRANT_I. last_owner updated to the winner.
- Grant latency: request sampled in cycle N, grant high in cycle N+1.

WRITE_D (exactly one cycle):
- mem_enable=1, mem_wr=1, mem_addr=d_addr, mem_wdata=d_wdata, d_write_done=1.
- Next state IDLE.

GRANT_x:
- x_grant=1.
- mem_enable = x_mem_read; mem_wr=0; mem_addr = x_addr.
- The non-owner's signals are ignored entirely.

Outstanding counter (increment and decrement in the same cycle leave it unchanged):
- Increments when mem_enable & ~mem_wr.
- Decrements when mem_data_valid & outstanding≠0.
- mem_data_valid with outstanding=0 is ignored and not routed.
- Overflow past 2^CNT_W−1 is a design error: flagged by a simulation assertion; the RTL saturates.

Routing:
- x_data_valid = mem_data_valid & x_grant & (outstanding≠0).
- Routing continues after x_req drops while reads are still outstanding.

Release:
- In GRANT_x, when x_req=0 and outstanding=0 → IDLE.
- One idle bubble cycle precedes the next grant; no direct handover.

Other rules:
- A d_write arriving during GRANT_I or GRANT_D waits; it is serviced in IDLE ahead of d_req.
- All outputs are combinational from registered state plus current inputs (Mealy on enable/addr). No combinational path from mem_data_valid to mem_enable.

Decomposition:
- Shared package: state encoding constants (IDLE, GRANT_I, GRANT_D, WRITE_D), the MEM_LATENCY default, and the 16-bit address/data width constant.
- One natural sub-module: mem_outstanding_ctr (up/down counter with saturation and zero flag), reused later for the D-cache write buffer.

Test Plan:
- I-only fill: i_req=1 at cycle 0, i_mem_read every granted cycle for 8 reads at 0x1230..0x123E. Required: i_grant at cycle 1; mem_addr tracks i_addr; 8 i_data_valid pulses; grant drops only after the 8th valid and i_req=0; IDLE one cycle.
- Simultaneous i_req and d_req from reset. Required: D granted first (last_owner=I). When D releases with I still pending, i_grant rises after one bubble cycle.
- d_write with data 0xBEEF at address 0x0040 while GRANT_I is active. Required: stalled, no mem_wr, until I releases. Then a single cycle with mem_enable=1, mem_wr=1, addr 0x0040, wdata 0xBEEF, and a d_write_done pulse.
- d_req drops one cycle after its last read issue, with 4 reads outstanding. Required: d_grant stays high until the 4 valids are routed to d_data_valid; i_data_valid stays 0 throughout.
- Spurious mem_data_valid in IDLE. Required: neither routed valid asserts; counter stays 0.
- rst=1 mid-GRANT_D with 3 outstanding. Required: next cycle all outputs 0, state IDLE. Later valids dropped; new i_req granted normally.
